full_subtractor_hs: RTL and testbench

- Registered ripple-borrow subtractor computing {bo, d} = a − b − bin over WIDTH bits.
- Each bit slice is a full subtractor built from two half subtractors plus an OR on the borrows.
- Default WIDTH=1 gives the classic 1-bit full subtractor (A, B, Bin → D, Bo).
- Used as a leaf arithmetic block wherever a registered borrow-chain subtract is needed.

---
 rtl/full_subtractor_hs_pkg.sv | 6 +
 rtl/full_subtractor_hs_if.sv | 31 +++
 rtl/full_subtractor_hs_half_subtractor.sv | 10 +
 rtl/full_subtractor_hs.sv | 87 ++++++++
 tb/tb_full_subtractor_hs.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/full_subtractor_hs_pkg.sv
// Shared constants for the registered ripple-borrow subtractor.
package full_subtractor_hs_pkg;

  localparam int DEFAULT_WIDTH = 1;

endpackage

// File: rtl/full_subtractor_hs_if.sv
// Operand/result bundle for full_subtractor_hs; ovf exists only with FULL_SUBTRACTOR_HS_OVF_EN.
interface full_subtractor_hs_if #(
  parameter int WIDTH = 1
);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic [WIDTH-1:0] d;
  logic             bo;
`ifdef FULL_SUBTRACTOR_HS_OVF_EN
  logic             ovf;
`endif

  modport master (
    output in_valid, a, b, bin,
`ifdef FULL_SUBTRACTOR_HS_OVF_EN
    input  ovf,
`endif
    input  out_valid, d, bo
  );

  modport slave (
    input  in_valid, a, b, bin,
`ifdef FULL_SUBTRACTOR_HS_OVF_EN
    output ovf,
`endif
    output out_valid, d, bo
  );
endinterface

// File: rtl/full_subtractor_hs_half_subtractor.sv
// Combinational half subtractor: difference x^y, borrow ~x&y.
module half_subtractor (
  input  logic x_i,
  input  logic y_i,
  output logic hd_o,
  output logic hb_o
);
  assign hd_o = x_i ^ y_i;
  assign hb_o = ~x_i & y_i;
endmodule

// File: rtl/full_subtractor_hs.sv
// Registered ripple-borrow subtractor {bo, d} = a - b - bin, one cycle latency.
// Optional signed-overflow output enabled by FULL_SUBTRACTOR_HS_OVF_EN.
module full_subtractor_hs
  import full_subtractor_hs_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic              clk,
  input logic              rst_n,
  full_subtractor_hs_if.slave bus
);

  logic [WIDTH:0]   borrow;
  logic [WIDTH-1:0] d1, b1, b2, d_next;

  logic [WIDTH-1:0] d_q, d_d;
  logic             bo_q, bo_d;
  logic             valid_q, valid_d;

  assign borrow[0] = bus.bin;

  // Each slice: two half subtractors with their borrows ORed into the next slice.
  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    half_subtractor u_hs1 (
      .x_i  (bus.a[i]),
      .y_i  (bus.b[i]),
      .hd_o (d1[i]),
      .hb_o (b1[i])
    );
    half_subtractor u_hs2 (
      .x_i  (d1[i]),
      .y_i  (borrow[i]),
      .hd_o (d_next[i]),
      .hb_o (b2[i])
    );
    assign borrow[i+1] = b1[i] | b2[i];
  end

`ifdef FULL_SUBTRACTOR_HS_OVF_EN
  logic ovf_q, ovf_d;
  logic ovf_next;

  assign ovf_next = (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]) & (d_next[WIDTH-1] ^ bus.a[WIDTH-1]);
`endif

  always_comb begin
    d_d     = d_q;
    bo_d    = bo_q;
    valid_d = bus.in_valid;
`ifdef FULL_SUBTRACTOR_HS_OVF_EN
    ovf_d   = ovf_q;
`endif
    if (bus.in_valid) begin
      d_d  = d_next;
      bo_d = borrow[WIDTH];
`ifdef FULL_SUBTRACTOR_HS_OVF_EN
      ovf_d = ovf_next;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d_q     <= '0;
      bo_q    <= 1'b0;
      valid_q <= 1'b0;
`ifdef FULL_SUBTRACTOR_HS_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      d_q     <= d_d;
      bo_q    <= bo_d;
      valid_q <= valid_d;
`ifdef FULL_SUBTRACTOR_HS_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.d         = d_q;
  assign bus.bo        = bo_q;
  assign bus.out_valid = valid_q;
`ifdef FULL_SUBTRACTOR_HS_OVF_EN
  assign bus.ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_full_subtractor_hs.sv
// Directed self-checking bench for full_subtractor_hs at WIDTH 1, 4 and 8.
module tb_full_subtractor_hs;
  import full_subtractor_hs_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  full_subtractor_hs_if #(.WIDTH(1)) if1 ();
  full_subtractor_hs_if #(.WIDTH(4)) if4 ();
  full_subtractor_hs_if #(.WIDTH(8)) if8 ();

  full_subtractor_hs #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  full_subtractor_hs #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
  full_subtractor_hs #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] d_tab;
    logic [7:0] bo_tab;
    logic [2:0] v;
    // index {a,b,bin}: d = 0,1,1,0,1,0,0,1  bo = 0,1,1,1,0,0,0,1
    d_tab  = 8'b1001_0110;
    bo_tab = 8'b1000_1110;

    rst_n = 1'b0;
    if1.in_valid = 1'b0; if1.a = '0; if1.b = '0; if1.bin = 1'b0;
    if4.in_valid = 1'b0; if4.a = '0; if4.b = '0; if4.bin = 1'b0;
    if8.in_valid = 1'b0; if8.a = '0; if8.b = '0; if8.bin = 1'b0;
    tick();
    tick();
    chk("rst_w1_d",  32'(if1.d), 32'h0);
    chk("rst_w1_bo", 32'(if1.bo), 32'h0);
    chk("rst_w1_ov", 32'(if1.out_valid), 32'h0);
    chk("rst_w4_d",  32'(if4.d), 32'h0);
    chk("rst_w8_d",  32'(if8.d), 32'h0);
    chk("rst_w8_ov", 32'(if8.out_valid), 32'h0);
`ifdef FULL_SUBTRACTOR_HS_OVF_EN
    chk("rst_w8_ovf", 32'(if8.ovf), 32'h0);
`endif

    // WIDTH=1 exhaustive, back-to-back
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      if1.in_valid = 1'b1;
      if1.a   = v[2];
      if1.b   = v[1];
      if1.bin = v[0];
      tick();
      chk($sformatf("w1_d_%0d", i),  32'(if1.d), 32'(d_tab[i]));
      chk($sformatf("w1_bo_%0d", i), 32'(if1.bo), 32'(bo_tab[i]));
      chk($sformatf("w1_ov_%0d", i), 32'(if1.out_valid), 32'h1);
    end
    if1.in_valid = 1'b0;

    // WIDTH=4 basic
    if4.in_valid = 1'b1; if4.a = 4'h3; if4.b = 4'h5; if4.bin = 1'b0;
    tick();
    chk("w4_35_d",  32'(if4.d), 32'hE);
    chk("w4_35_bo", 32'(if4.bo), 32'h1);
    chk("w4_35_ov", 32'(if4.out_valid), 32'h1);
    if4.a = 4'hA; if4.b = 4'h3; if4.bin = 1'b1;
    tick();
    chk("w4_a3_d",  32'(if4.d), 32'h6);
    chk("w4_a3_bo", 32'(if4.bo), 32'h0);

    // Hold with changing operands
    if4.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if4.a = 4'(i + 1);
      if4.b = 4'(9 + i);
      if4.bin = 1'(i);
      tick();
      chk($sformatf("hold_d_%0d", i),  32'(if4.d), 32'h6);
      chk($sformatf("hold_bo_%0d", i), 32'(if4.bo), 32'h0);
      chk($sformatf("hold_ov_%0d", i), 32'(if4.out_valid), 32'h0);
    end

    // Reset mid-stream
    if4.in_valid = 1'b1; if4.a = 4'h7; if4.b = 4'h2; if4.bin = 1'b0;
    tick();
    chk("strm_d", 32'(if4.d), 32'h5);
    if4.a = 4'h9; if4.b = 4'h1;
    rst_n = 1'b0;
    tick();
    chk("mrst_d",  32'(if4.d), 32'h0);
    chk("mrst_bo", 32'(if4.bo), 32'h0);
    chk("mrst_ov", 32'(if4.out_valid), 32'h0);
    rst_n = 1'b1;
    if4.a = 4'h1; if4.b = 4'h2; if4.bin = 1'b0;
    tick();
    chk("post_d",  32'(if4.d), 32'hF);
    chk("post_bo", 32'(if4.bo), 32'h1);
    chk("post_ov", 32'(if4.out_valid), 32'h1);
    if4.in_valid = 1'b0;

    // WIDTH=8 borrow ripple
    if8.in_valid = 1'b1; if8.a = 8'h00; if8.b = 8'h00; if8.bin = 1'b1;
    tick();
    chk("w8_rip_d",  32'(if8.d), 32'hFF);
    chk("w8_rip_bo", 32'(if8.bo), 32'h1);
`ifdef FULL_SUBTRACTOR_HS_OVF_EN
    chk("w8_rip_ovf", 32'(if8.ovf), 32'h0);
`endif
    if8.a = 8'h80; if8.b = 8'h7F; if8.bin = 1'b0;
    tick();
    chk("w8_807f_d",  32'(if8.d), 32'h01);
    chk("w8_807f_bo", 32'(if8.bo), 32'h0);
`ifdef FULL_SUBTRACTOR_HS_OVF_EN
    chk("w8_807f_ovf", 32'(if8.ovf), 32'h1);
`endif
    if8.a = 8'h80; if8.b = 8'h01; if8.bin = 1'b0;
    tick();
    chk("w8_8001_d",  32'(if8.d), 32'h7F);
    chk("w8_8001_bo", 32'(if8.bo), 32'h0);
`ifdef FULL_SUBTRACTOR_HS_OVF_EN
    chk("w8_8001_ovf", 32'(if8.ovf), 32'h1);
`endif
    if8.a = 8'h05; if8.b = 8'h03; if8.bin = 1'b0;
    tick();
    chk("w8_0503_d",  32'(if8.d), 32'h02);
    chk("w8_0503_bo", 32'(if8.bo), 32'h0);
`ifdef FULL_SUBTRACTOR_HS_OVF_EN
    chk("w8_0503_ovf", 32'(if8.ovf), 32'h0);
`endif
    if8.in_valid = 1'b0;
    tick();
    chk("w8_idle_ov", 32'(if8.out_valid), 32'h0);
    chk("w8_idle_d",  32'(if8.d), 32'h02);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
